// File: rtl/display_pkg.sv
// Shared types and defaults for the multiplexed 7-segment display scanner.
package display_pkg;

  localparam int DEF_N_DIGITS  = 6;
  localparam int DEF_SCAN_DIV  = 50000;
  localparam int DEF_BLANK_CYC = 2;
  localparam int BCD_W         = 4;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot timer: counts 0..SCAN_DIV-1 while running and flags the key slot positions.
module scan_tick_gen
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic blank_end,
  output logic pre_end,
  output logic slot_end
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_PRE   = CNT_W'(SCAN_DIV - 2);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero while stopped so the first slot after enable starts cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || cnt == SLOT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign blank_end = (cnt == BLANK_LAST);
  assign pre_end   = (cnt == SLOT_PRE);
  assign slot_end  = (cnt == SLOT_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed display scanner: per-digit BLANK/DRIVE slots, frame snapshot, blink gating.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS  = DEF_N_DIGITS,
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [BCD_W*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]       blink_mask,
  input  logic                      blink_tick,
  output logic [BCD_W-1:0]          bcd_out,
  output logic [N_DIGITS-1:0]       digit_en_n,
  output logic                      frame_done,
  output scan_state_t               dbg_state
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  scan_state_t               state;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          idx_nx;
  logic [BCD_W*N_DIGITS-1:0] frame;
  logic                      phase;
  logic                      phase_nx;
  logic [N_DIGITS-1:0]       drive_en_n;
  logic                      run;
  logic                      blank_end;
  logic                      pre_end;
  logic                      slot_end;

  assign run       = enable && (state != S_OFF);
  assign phase_nx  = phase ^ blink_tick;
  assign idx_nx    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign dbg_state = state;

  scan_tick_gen #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .blank_end (blank_end),
    .pre_end   (pre_end),
    .slot_end  (slot_end)
  );

  // Blink uses the next phase so a tick on a slot boundary lands in the new slot.
  always_comb begin
    drive_en_n = '1;
    if (!(phase_nx && blink_mask[idx])) begin
      drive_en_n[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_OFF;
      idx        <= '0;
      phase      <= 1'b0;
      frame      <= '0;
      bcd_out    <= '0;
      digit_en_n <= '1;
      frame_done <= 1'b0;
    end else begin
      phase      <= phase_nx;
      frame_done <= 1'b0;
      if (!enable) begin
        state      <= S_OFF;
        idx        <= '0;
        digit_en_n <= '1;
      end else begin
        case (state)
          S_OFF: begin
            state   <= S_BLANK;
            idx     <= '0;
            frame   <= digits_in;
            bcd_out <= digits_in[BCD_W-1:0];
          end
          S_BLANK: begin
            if (blank_end) begin
              state      <= S_DRIVE;
              digit_en_n <= drive_en_n;
            end
          end
          S_DRIVE: begin
            if (slot_end) begin
              state      <= S_BLANK;
              idx        <= idx_nx;
              digit_en_n <= '1;
              // Digit 0 reads the live input because the snapshot lands on this same edge.
              if (idx_nx == '0) begin
                frame   <= digits_in;
                bcd_out <= digits_in[BCD_W-1:0];
              end else begin
                bcd_out <= frame[{idx_nx, 2'b00} +: BCD_W];
              end
            end else begin
              digit_en_n <= drive_en_n;
              frame_done <= (idx == LAST_IDX) && pre_end;
            end
          end
          default: begin
            state      <= S_OFF;
            digit_en_n <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
module tb_display_scan_ctrl;
  import display_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  blink_mask;
  logic        blink_tick;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en_n;
  logic        frame_done;
  scan_state_t dbg_state;

  int   n_cmp = 0;
  int   n_err = 0;
  logic onehot_on = 1'b0;

  display_scan_ctrl #(
    .N_DIGITS  (4),
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digits_in  (digits_in),
    .blink_mask (blink_mask),
    .blink_tick (blink_tick),
    .bcd_out    (bcd_out),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs for scan cycle k counted from the first edge after enable.
  task automatic check_cycle(input int k, input logic [3:0] exp_bcd, input logic blanked);
    int         slot;
    int         c;
    logic [3:0] exp_en;
    slot = (k / 8) % 4;
    c    = k % 8;
    exp_en = (c >= 2 && !blanked) ? ~(4'b0001 << slot) : 4'b1111;
    check($sformatf("bcd_k%0d", k), 32'(bcd_out), 32'(exp_bcd));
    check($sformatf("en_k%0d", k), 32'(digit_en_n), 32'(exp_en));
    check($sformatf("fd_k%0d", k), 32'(frame_done), 32'(k % 32 == 31));
  endtask

  always @(negedge clk) begin
    if (onehot_on) begin
      n_cmp++;
      assert ($countones(~digit_en_n) <= 1) else begin
        n_err++;
        $error("FAIL onehot: digit_en_n=%b, required at most one bit low", digit_en_n);
      end
    end
  end

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    blink_tick = 1'b0;
    blink_mask = 4'b0000;
    digits_in  = 16'h4321;

    #12;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_en", 32'(digit_en_n), 32'hF);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_OFF));

    @(negedge clk);
    reset     = 1'b1;
    onehot_on = 1'b1;
    step();
    check("off_en", 32'(digit_en_n), 32'hF);
    check("off_state", 32'(dbg_state), 32'(S_OFF));

    // Four frames: 4321, then 9999 from the mid-frame change, blinked digit 1, unblinked
    enable = 1'b1;
    for (int k = 0; k < 128; k++) begin
      blink_tick = (k == 64 || k == 96);
      if (k == 64) blink_mask = 4'b0010;
      if (k == 12) digits_in = 16'h9999;
      step();
      check_cycle(k, (k < 32) ? 4'(k / 8 + 1) : 4'h9,
                  (k >= 64 && k < 96 && (k / 8) % 4 == 1));
    end

    // Non-BCD nibble on digit 2, then drop enable while it is driven
    digits_in = 16'h0B07;
    for (int k = 128; k < 149; k++) begin
      logic [3:0] exp_bcd;
      step();
      case ((k / 8) % 4)
        0:       exp_bcd = 4'h7;
        1:       exp_bcd = 4'h0;
        default: exp_bcd = 4'hB;
      endcase
      check_cycle(k, exp_bcd, 1'b0);
    end
    check("drv2_state", 32'(dbg_state), 32'(S_DRIVE));

    enable = 1'b0;
    step();
    check("dis_en", 32'(digit_en_n), 32'hF);
    check("dis_state", 32'(dbg_state), 32'(S_OFF));
    check("dis_fd", 32'(frame_done), 32'h0);
    check("dis_bcd_hold", 32'(bcd_out), 32'hB);
    step();
    check("off2_en", 32'(digit_en_n), 32'hF);
    check("off2_state", 32'(dbg_state), 32'(S_OFF));

    enable = 1'b1;
    step();
    check("re_state", 32'(dbg_state), 32'(S_BLANK));
    check("re_bcd", 32'(bcd_out), 32'h7);
    check("re_en", 32'(digit_en_n), 32'hF);
    step();
    step();
    check("re_drive_en", 32'(digit_en_n), 32'hE);
    check("re_drive_state", 32'(dbg_state), 32'(S_DRIVE));

    // Asynchronous reset in the middle of a DRIVE cycle
    #2;
    reset = 1'b0;
    #1;
    check("arst_en", 32'(digit_en_n), 32'hF);
    check("arst_bcd", 32'(bcd_out), 32'h0);
    check("arst_state", 32'(dbg_state), 32'(S_OFF));
    check("arst_fd", 32'(frame_done), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    step();
    check("post_state", 32'(dbg_state), 32'(S_BLANK));
    check("post_bcd", 32'(bcd_out), 32'h7);

    onehot_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
